polyphase_output_quantizer: RTL and testbench
=============================================

# polyphase_output_quantizer

- Terminal stage of the polyphase FIR MAC chain.
- Takes the full-precision `carry_out` of the last MAC in the chain and rounds, shifts and saturates it to `DATA_WIDTH`.
- Buffers the results in a small FIFO and presents them on a valid/ready output stream.
- Generates the chain-wide `ce_calculate` so that back-pressure stalls the whole MAC chain without losing results.

## Interface
Parameters:
- `CARRY_WIDTH`, 48, width of the accumulated carry from the MAC chain
- `DATA_WIDTH`, 16, output sample width (signed)
- `OUTPUT_SHIFT`, 14, arithmetic right shift applied after rounding; range 1..`CARRY_WIDTH`-`DATA_WIDTH`
- `ROUND_MODE`, 1, 0 = truncate (floor), 1 = round half up
- `LATENCY`, 3, number of `ce_calculate` advances from accepting an input sample to its result appearing on `carry_in`; minimum 1
- `FIFO_DEPTH`, 4, output FIFO entries; power of two, minimum 2

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  a new sample is presented to the head of the MAC chain this cycle
- `in_ready`  out  1  the chain accepts the sample; equals `ce_calculate`
- `ce_calculate`  out  1  clock enable broadcast to every MAC in the chain
- `carry_in`  in  `CARRY_WIDTH`  `carry_out` of the last MAC, signed
- `m_data`  out  `DATA_WIDTH`  quantized sample, signed
- `m_valid`  out  1  `m_data` is valid
- `m_ready`  in  1  downstream accepts `m_data`
- `overflow`  out  1  sticky flag: saturation has occurred since reset
- `level`  out  $clog2(`FIFO_DEPTH`)+1  current FIFO occupancy

## Operation
- `ce_calculate` = (`level` != `FIFO_DEPTH`) || (`m_valid` && `m_ready`). Combinational; `m_ready` → `ce_calculate` is the only combinational input-to-output path.
- Valid tracking uses a `LATENCY`-bit shift register `vpipe`.
  - It advances only on `ce_calculate`: `vpipe[0]` ← `in_valid`, and each stage takes the previous one.
  - The tail `vpipe[LATENCY-1]` marks `carry_in` as valid.
- Push: on a cycle with `ce_calculate` && tail set, the quantized `carry_in` is written into the FIFO.
  - The stall rule guarantees the FIFO is never full at a push, so no result is ever dropped.
- Quantization (combinational, sign-extended to `CARRY_WIDTH`+1 bits):
  - r = `carry_in` + (`ROUND_MODE` ? 2^(`OUTPUT_SHIFT`-1) : 0).
  - s = r >>> `OUTPUT_SHIFT`.
  - If s > 2^(`DATA_WIDTH`-1)-1, output max positive; if s < -2^(`DATA_WIDTH`-1), output max negative; otherwise output s[`DATA_WIDTH`-1:0].
  - Either saturation case sets `overflow`, and it stays set until reset.
- Pop: on `m_valid` && `m_ready`.
  - Simultaneous push and pop leaves `level` unchanged, and ordering is preserved.
  - Push into an empty FIFO with no pop makes `m_valid` rise on the next cycle.
- Gaps in `in_valid` propagate as bubbles: no push occurs for that slot, and the chain keeps advancing.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `overflow`=0, `level`=0, `vpipe`=0. `ce_calculate` and `in_ready` are therefore 1 after reset.
- Reset mid-operation clears the FIFO and `vpipe`. In-flight chain contents are discarded because the MACs reset on the same `reset`.
- A sample accepted at edge N (with no stall) is pushed at edge N+`LATENCY`-1 and is visible on `m_valid`/`m_data` from cycle N+`LATENCY`.
- `m_data` and `m_valid` are registered FIFO outputs.
- While `m_valid` && !`m_ready`, `m_data` holds stable.
- Full FIFO with `m_ready`=0: `ce_calculate`=0. The chain, `vpipe` and `carry_in` freeze, and the stall lifts in the same cycle `m_ready` goes high.
- Sustained throughput is 1 sample/cycle when `m_ready` is held at 1.

## Structure
- Shared package/header `polyphase_pkg`: `ROUND_TRUNCATE`=0, `ROUND_HALF_UP`=1, and a saturation-limit helper keyed on `DATA_WIDTH`.
- Sub-module `polyphase_sample_fifo`: synchronous FIFO with registered output and `level` count. The quantizer, `vpipe` and the stall logic live in the top module.

## Test plan
Defaults apply unless stated.
- Rounding with `ROUND_MODE`=1:
  - `carry_in`=0x4000 → `m_data`=1.
  - 0x2000 → 1.
  - 0x1FFF → 0.
  - -0x2000 → 0.
  - -0x2001 → -1.
  - `overflow` stays 0 throughout.
- Truncation with `ROUND_MODE`=0: `carry_in` 0x7FFF → 1; -1 → -1.
- Saturation:
  - `carry_in`=2^30 → 0x7FFF, and `overflow` rises 1 cycle after the push and stays high.
  - -2^31 → 0x8000.
- Latency: single `in_valid` pulse at cycle 10 with `m_ready`=1 → `m_valid` high exactly at cycle 13 for one cycle.
- Back-pressure:
  - `m_ready`=0 with continuous `in_valid` → after 4 pushes `level`=4 and `ce_calculate`=0.
  - Raising `m_ready` → `ce_calculate`=1 in the same cycle; all samples emerge in order with none lost or duplicated.
- Reset with `level`=3 → next cycle `m_valid`=0, `level`=0, `overflow`=0, `ce_calculate`=1.

Source files
------------

// File: rtl/polyphase_pkg.sv
// Shared definitions for the polyphase FIR output stage: rounding mode
// encodings and the signed saturation limits for a given output width.
package polyphase_pkg;

  localparam int ROUND_TRUNCATE = 0;
  localparam int ROUND_HALF_UP  = 1;

  // Largest positive value representable in a signed word of data_width bits.
  function automatic longint sat_max(input int data_width);
    return (64'sd1 <<< (data_width - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in a signed word of data_width bits.
  function automatic longint sat_min(input int data_width);
    return -(64'sd1 <<< (data_width - 1));
  endfunction

endpackage

// File: rtl/polyphase_sample_fifo.sv
// Synchronous sample FIFO with a registered head word. The output register
// holds the oldest entry; the array holds the rest. level counts both, so a
// full FIFO is DEPTH entries including the one presented on m_data.
//
// Handshake: a word transfers on a cycle where m_valid && m_ready are both
// high at the rising edge; m_data is held stable while m_valid && !m_ready.
// push must only be asserted when level < DEPTH or a pop happens that cycle.
module polyphase_sample_fifo
  import polyphase_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [LW-1:0]    level
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             pop;
  logic [LW-1:0]    mem_count;

  // Next-state for the head register, storage array, pointers and level.
  always_comb begin
    pop       = m_valid_q & m_ready;
    mem_count = level_q - LW'(m_valid_q);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    level_d   = level_q + LW'(push) - LW'(pop);
    if (!m_valid_q || pop) begin
      // Head is free this edge: refill from the array first to keep order.
      if (mem_count != '0) begin
        m_data_d  = mem_q[rd_ptr_q];
        m_valid_d = 1'b1;
        rd_ptr_d  = rd_ptr_q + 1'b1;
        if (push) begin
          mem_d[wr_ptr_q] = push_data;
          wr_ptr_d        = wr_ptr_q + 1'b1;
        end
      end else if (push) begin
        m_data_d  = push_data;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
  end

  // Control and head registers, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign level   = level_q;

endmodule

// File: rtl/polyphase_output_quantizer.sv
// Terminal stage of the polyphase FIR MAC chain: rounds, shifts and
// saturates the last MAC's carry, buffers results, and produces the
// chain-wide clock enable so that downstream back-pressure freezes the
// whole chain instead of dropping results.
module polyphase_output_quantizer
  import polyphase_pkg::*;
#(
  parameter int CARRY_WIDTH  = 48,
  parameter int DATA_WIDTH   = 16,
  parameter int OUTPUT_SHIFT = 14,
  parameter int ROUND_MODE   = 1,
  parameter int LATENCY      = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int LW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   ce_calculate,
  input  logic [CARRY_WIDTH-1:0] carry_in,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   overflow,
  output logic [LW-1:0]          level
);

  localparam logic signed [CARRY_WIDTH:0] ROUND_ADD =
    (ROUND_MODE == ROUND_HALF_UP) ? ({{CARRY_WIDTH{1'b0}}, 1'b1} << (OUTPUT_SHIFT - 1)) : '0;
  localparam logic signed [CARRY_WIDTH:0] SAT_MAX = (CARRY_WIDTH + 1)'(sat_max(DATA_WIDTH));
  localparam logic signed [CARRY_WIDTH:0] SAT_MIN = (CARRY_WIDTH + 1)'(sat_min(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  // Valid tracking: bit 0 is the sample offered this cycle, each higher bit
  // is one chain advance later; the top bit says carry_in is a real result.
  logic [LATENCY-1:0] vpipe;
  logic               push;
  logic               overflow_q, overflow_d;
  logic               sat;
  logic signed [CARRY_WIDTH:0] rounded;
  logic signed [CARRY_WIDTH:0] shifted;
  logic [DATA_WIDTH-1:0]       quantized;
  logic [DATA_WIDTH-1:0]       fifo_data;
  logic                        fifo_valid;
  logic [LW-1:0]               fifo_level;

  // Stall only when full and nothing leaves; the pop frees the slot the push needs.
  assign ce_calculate = (fifo_level != LW'(FIFO_DEPTH)) || (fifo_valid && m_ready);
  assign in_ready     = ce_calculate;
  assign push         = ce_calculate && vpipe[LATENCY-1];

  if (LATENCY > 1) begin : gen_vpipe
    logic [LATENCY-2:0] vpipe_q, vpipe_d;

    // Shift the valid markers only when the MAC chain advances.
    always_comb begin
      vpipe_d = vpipe_q;
      if (ce_calculate) begin
        vpipe_d = vpipe[LATENCY-2:0];
      end
    end

    // Valid marker registers.
    always_ff @(posedge clock) begin
      if (reset) begin
        vpipe_q <= '0;
      end else begin
        vpipe_q <= vpipe_d;
      end
    end

    assign vpipe = {vpipe_q, in_valid};
  end else begin : gen_no_vpipe
    assign vpipe = in_valid;
  end

  // Round, arithmetic shift, then clamp into the signed output range.
  always_comb begin
    rounded   = $signed({carry_in[CARRY_WIDTH-1], carry_in}) + ROUND_ADD;
    shifted   = rounded >>> OUTPUT_SHIFT;
    sat       = 1'b0;
    quantized = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      quantized = OUT_MAX;
      sat       = 1'b1;
    end else if (shifted < SAT_MIN) begin
      quantized = OUT_MIN;
      sat       = 1'b1;
    end
    overflow_d = overflow_q | (push & sat);
  end

  // Sticky saturation flag, set on the edge that stores a clamped result.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  polyphase_sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (quantized),
    .m_data    (fifo_data),
    .m_valid   (fifo_valid),
    .m_ready   (m_ready),
    .level     (fifo_level)
  );

  assign m_data   = fifo_data;
  assign m_valid  = fifo_valid;
  assign level    = fifo_level;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_polyphase_output_quantizer.sv
// Bench for polyphase_output_quantizer: a two-stage MAC chain model feeds
// carry_in, expected quantized words are queued when a result enters the
// FIFO and compared when the DUT hands one out. A second instance with
// truncation shares the inputs.
module tb_polyphase_output_quantizer;

  localparam int CW = 48;
  localparam int DW = 16;
  localparam int LW = 3;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic [CW-1:0] in_data;
  logic [CW-1:0] carry_in;
  logic          m_ready;

  logic          in_ready_r, ce_calculate, m_valid_r, overflow_r;
  logic [DW-1:0] m_data_r;
  logic [LW-1:0] level_r;
  logic          in_ready_t, ce_t, m_valid_t, overflow_t;
  logic [DW-1:0] m_data_t;
  logic [LW-1:0] level_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // MAC chain model: a result reaches carry_in two advances after acceptance.
  logic          st_v [2];
  logic [CW-1:0] st_d [2];

  polyphase_output_quantizer #(.ROUND_MODE(1)) dut_round (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_r),
    .ce_calculate(ce_calculate), .carry_in(carry_in), .m_data(m_data_r),
    .m_valid(m_valid_r), .m_ready(m_ready), .overflow(overflow_r), .level(level_r)
  );

  polyphase_output_quantizer #(.ROUND_MODE(0)) dut_trunc (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
    .ce_calculate(ce_t), .carry_in(carry_in), .m_data(m_data_t),
    .m_valid(m_valid_t), .m_ready(m_ready), .overflow(overflow_t), .level(level_t)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign carry_in = st_d[1];

  always @(posedge clock) begin
    if (reset) begin
      st_v[0] <= 1'b0;
      st_v[1] <= 1'b0;
      st_d[0] <= '0;
      st_d[1] <= '0;
    end else if (ce_calculate) begin
      st_v[0] <= in_valid;
      st_d[0] <= in_data;
      st_v[1] <= st_v[0];
      st_d[1] <= st_d[0];
    end
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_q(input logic [CW-1:0] c, input bit half_up);
    longint v;
    v = longint'($signed(c));
    if (half_up) v = v + 64'sd8192;
    v = v >>> 14;
    if (v > 64'sd32767) v = 64'sd32767;
    if (v < -64'sd32768) v = -64'sd32768;
    return v[15:0];
  endfunction

  // scoreboard: compare on pop, then enqueue what the coming push will store
  always @(negedge clock) begin
    logic [31:0] e;
    #2;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (m_valid_r && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(m_data_r), -64'sd1);
        end else begin
          e = exp_q.pop_front();
          check("data_round", 64'($signed(m_data_r)), 64'($signed(e[15:0])));
          check("data_trunc", 64'($signed(m_data_t)), 64'($signed(e[31:16])));
        end
      end
      if (ce_calculate && st_v[1]) begin
        exp_q.push_back({model_q(carry_in, 1'b0), model_q(carry_in, 1'b1)});
      end
    end
  end

  // driver tasks
  task automatic send(input logic [CW-1:0] d);
    logic acc;
    int   tries;
    in_valid = 1'b1;
    in_data  = d;
    tries    = 0;
    do begin
      #1 acc = ce_calculate;
      @(negedge clock);
      tries++;
    end while (!acc && tries < 300);
    if (!acc) check("send_timeout", 64'(acc), 64'sd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_valid_r) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("drain_timeout", 64'(n < 200), 64'sd1);
  endtask

  logic signed [CW-1:0] vals [7];
  logic rand_done;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    m_ready  = 1'b1;
    rand_done = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check("rst_m_valid", 64'(m_valid_r), 64'sd0);
    check("rst_m_data", 64'(m_data_r), 64'sd0);
    check("rst_overflow", 64'(overflow_r), 64'sd0);
    check("rst_level", 64'(level_r), 64'sd0);
    check("rst_ce", 64'(ce_calculate), 64'sd1);
    check("rst_in_ready", 64'(in_ready_r), 64'sd1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // rounding and truncation points
    vals[0] = 48'sh4000;  vals[1] = 48'sh2000; vals[2] = 48'sh1FFF;
    vals[3] = -48'sh2000; vals[4] = -48'sh2001;
    vals[5] = 48'sh7FFF;  vals[6] = -48'sd1;
    foreach (vals[i]) send(vals[i]);
    idle(1);
    drain();
    check("round_no_ovf", 64'(overflow_r), 64'sd0);
    check("trunc_no_ovf", 64'(overflow_t), 64'sd0);

    // latency: one pulse, m_valid for exactly one cycle two edges later
    idle(3);
    in_valid = 1'b1;
    in_data  = 48'sh10000;
    @(negedge clock);
    in_valid = 1'b0;
    #1 check("lat_edge_n", 64'(m_valid_r), 64'sd0);
    @(negedge clock);
    #1 check("lat_edge_n1", 64'(m_valid_r), 64'sd0);
    @(negedge clock);
    #1 check("lat_edge_n2", 64'(m_valid_r), 64'sd1);
    @(negedge clock);
    #1 check("lat_edge_n3", 64'(m_valid_r), 64'sd0);
    drain();

    // saturation
    send(48'sh4000_0000);
    idle(0);
    begin
      int n;
      n = 0;
      while (!m_valid_r && n < 20) begin
        @(negedge clock);
        n++;
      end
      #1 check("sat_pos_ovf", 64'(overflow_r), 64'sd1);
    end
    send(-48'sh8000_0000);
    idle(5);
    drain();
    check("sat_ovf_sticky", 64'(overflow_r), 64'sd1);

    // back-pressure: fill with m_ready low, then release
    m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(48'(i * 16384 + 100));
        in_valid = 1'b0;
      end
      begin
        repeat (12) @(negedge clock);
        #1;
        check("bp_level", 64'(level_r), 64'sd4);
        check("bp_ce", 64'(ce_calculate), 64'sd0);
        check("bp_in_ready", 64'(in_ready_r), 64'sd0);
        @(negedge clock);
        m_ready = 1'b1;
        #1 check("bp_release_ce", 64'(ce_calculate), 64'sd1);
      end
    join
    idle(1);
    drain();

    // random traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          logic [31:0] u;
          logic signed [CW-1:0] v;
          u = $urandom;
          v = {{16{u[31]}}, u};
          v = v >>> $urandom_range(0, 18);
          send(v);
          idle($urandom_range(0, 2));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clock);
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_ready = 1'b1;
    idle(1);
    drain();

    // reset with three entries waiting
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(48'(i * 32768));
    idle(0);
    begin
      int n;
      n = 0;
      while (level_r != 3'd3 && n < 20) begin
        @(negedge clock);
        n++;
      end
      #1 check("pre_rst_level", 64'(level_r), 64'sd3);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("mid_rst_m_valid", 64'(m_valid_r), 64'sd0);
    check("mid_rst_level", 64'(level_r), 64'sd0);
    check("mid_rst_overflow", 64'(overflow_r), 64'sd0);
    check("mid_rst_ce", 64'(ce_calculate), 64'sd1);
    check("mid_rst_trunc_ovf", 64'(overflow_t), 64'sd0);
    check("mid_rst_trunc_lvl", 64'(level_t), 64'sd0);
    reset   = 1'b0;
    m_ready = 1'b1;
    send(48'sh4000);
    idle(1);
    drain();

    // final report
    check("queue_empty", 64'(exp_q.size()), 64'sd0);
    check("trunc_idle", 64'({m_valid_t, ce_t, in_ready_t}), 64'sd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
